// File: rtl/matrix_scan.sv
// Row scanner for a multiplexed display/keyboard matrix: auto-scan with a
// per-row dwell prescaler, or manual row select. MATRIX_SCAN_BLANK_EN adds anti-ghost blanking.
module matrix_scan #(
  parameter int ROWS  = 7,
  parameter int SEL_W = 3,
  parameter int PRESC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic             Mode,
  input  logic [SEL_W-1:0] Ch,
  output logic [ROWS-1:0]  Line,
  output logic [SEL_W-1:0] RowIdx,
  output logic             FrameDone,
  output logic             Display
);

  localparam int PW = (PRESC > 2) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
  localparam logic [SEL_W-1:0] LAST_ROW   = SEL_W'(ROWS - 1);

  logic [PW-1:0]    presc_r, presc_s;
  logic [SEL_W-1:0] row_r, row_s;
  logic [ROWS-1:0]  line_r, line_s;
  logic             frame_r, frame_s;
  logic             display_r, display_s;
  // High when the next enabled auto-mode edge must start a fresh frame
  // (after reset or after leaving manual mode).
  logic             restart_r, restart_s;

  function automatic logic [ROWS-1:0] onehot(input logic [SEL_W-1:0] r);
    logic [ROWS-1:0] oh;
    oh = '0;
    for (int i = 0; i < ROWS; i++) begin
      oh[i] = (r == SEL_W'(i));
    end
    return oh;
  endfunction

  // Next-state for prescaler, row, line enables and status outputs
  always_comb begin
    presc_s   = presc_r;
    row_s     = row_r;
    restart_s = restart_r;
    frame_s   = 1'b0;
    line_s    = '0;
    display_s = Mode & (&Ch);
    if (En) begin
      restart_s = Mode;
      if (Mode) begin
        row_s   = Ch;
        presc_s = '0;
      end else if (restart_r) begin
        row_s   = '0;
        presc_s = '0;
      end else if (presc_r == PRESC_LAST) begin
        presc_s = '0;
        if (row_r == LAST_ROW) begin
          row_s   = '0;
          frame_s = 1'b1;
        end else begin
          row_s   = row_r + SEL_W'(1);
        end
      end else begin
        presc_s = presc_r + PW'(1);
      end
`ifdef MATRIX_SCAN_BLANK_EN
      line_s = (row_s != row_r) ? '0 : onehot(row_s);
`else
      line_s = onehot(row_s);
`endif
    end else begin
      line_s = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r   <= '0;
      row_r     <= '0;
      line_r    <= '0;
      frame_r   <= 1'b0;
      display_r <= 1'b0;
      restart_r <= 1'b1;
    end else begin
      presc_r   <= presc_s;
      row_r     <= row_s;
      line_r    <= line_s;
      frame_r   <= frame_s;
      display_r <= display_s;
      restart_r <= restart_s;
    end
  end

  assign Line      = line_r;
  assign RowIdx    = row_r;
  assign FrameDone = frame_r;
  assign Display   = display_r;

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan (ROWS=7, PRESC=4, SEL_W=3): directed
// scenarios plus random stimulus against a behavioural row-scan model.
module tb_matrix_scan;
  localparam int ROWS = 7, SEL_W = 3, PRESC = 4;

  logic             clk = 1'b0, rst_n = 1'b0, En = 1'b0, Mode = 1'b0;
  logic [SEL_W-1:0] Ch = '0;
  logic [ROWS-1:0]  Line;
  logic [SEL_W-1:0] RowIdx;
  logic             FrameDone, Display;

  matrix_scan #(.ROWS(ROWS), .SEL_W(SEL_W), .PRESC(PRESC)) dut (
    .clk(clk), .rst_n(rst_n), .En(En), .Mode(Mode), .Ch(Ch),
    .Line(Line), .RowIdx(RowIdx), .FrameDone(FrameDone), .Display(Display)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  // Model: current row, cycles already spent in this row's dwell, and whether
  // the next enabled auto cycle starts a new frame.
  int m_row = 0, m_cnt = 0, m_fresh = 1;
  int m_line = 0, m_fd = 0, m_disp = 0;
  int fd_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_cnt = 0; m_fresh = 1; m_line = 0; m_fd = 0; m_disp = 0;
  endtask

  task automatic step(input logic en, input logic mode, input logic [SEL_W-1:0] ch);
    int new_row;
    En = en; Mode = mode; Ch = ch;
    @(posedge clk);
    m_disp  = (mode && ch == 3'd7) ? 1 : 0;
    m_fd    = 0;
    new_row = m_row;
    if (!en) begin
      m_line = 0;
    end else begin
      if (mode) begin
        new_row = ch; m_cnt = 0;
      end else if (m_fresh != 0) begin
        new_row = 0; m_cnt = 0;
      end else if (m_cnt == PRESC - 1) begin
        m_cnt   = 0;
        m_fd    = (m_row == ROWS - 1) ? 1 : 0;
        new_row = (m_row + 1) % ROWS;
      end else begin
        m_cnt++;
      end
      m_line = (new_row < ROWS) ? (1 << new_row) : 0;
`ifdef MATRIX_SCAN_BLANK_EN
      if (new_row != m_row) m_line = 0;
`endif
      m_fresh = mode ? 1 : 0;
    end
    m_row = new_row;
    #1;
    chk("line", 32'(Line), 32'(m_line));
    chk("row_idx", 32'(RowIdx), 32'(m_row));
    chk("frame_done", 32'(FrameDone), 32'(m_fd));
    chk("display", 32'(Display), 32'(m_disp));
  endtask

  initial begin
    int guard;
    logic en_r, mode_r;

    // Reset state
    #12;
    chk("rst_line", 32'(Line), 32'd0);
    chk("rst_row", 32'(RowIdx), 32'd0);
    chk("rst_fd", 32'(FrameDone), 32'd0);
    chk("rst_disp", 32'(Display), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // First dwell after release: row 0 for PRESC clocks, then row 1
    for (int i = 0; i < PRESC; i++) begin
      step(1'b1, 1'b0, 3'd0);
      chk("first_dwell_line", 32'(Line), 32'd1);
      chk("first_dwell_row", 32'(RowIdx), 32'd0);
    end
    step(1'b1, 1'b0, 3'd0);
`ifndef MATRIX_SCAN_BLANK_EN
    chk("row1_line", 32'(Line), 32'b0000010);
`endif
    chk("row1_idx", 32'(RowIdx), 32'd1);

    // One full frame worth of auto scan: exactly one FrameDone pulse
    fd_pulses = 0;
    for (int i = 0; i < ROWS * PRESC; i++) begin
      step(1'b1, 1'b0, 3'd0);
      if (FrameDone) fd_pulses++;
    end
    chk("frame_pulses", 32'(fd_pulses), 32'd1);

    // Freeze mid row 3
    guard = 0;
    while (!(m_row == 3 && m_cnt == 1) && guard < 100) begin
      step(1'b1, 1'b0, 3'd0);
      guard++;
    end
    chk("reach_row3_in_budget", 32'(guard < 100), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 3'd0);
    chk("frozen_row", 32'(RowIdx), 32'd3);
    chk("frozen_line", 32'(Line), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 3'd0);

    // Manual select, out-of-range channel, return to auto
    step(1'b1, 1'b1, 3'd5);
    chk("manual5_row", 32'(RowIdx), 32'd5);
`ifndef MATRIX_SCAN_BLANK_EN
    chk("manual5_line", 32'(Line), 32'b0100000);
`endif
    step(1'b1, 1'b1, 3'd7);
    chk("manual7_line", 32'(Line), 32'd0);
    chk("manual7_disp", 32'(Display), 32'd1);
    step(1'b1, 1'b1, 3'd5);
    step(1'b1, 1'b0, 3'd0);
    chk("restart_row", 32'(RowIdx), 32'd0);
    chk("restart_line", 32'(Line), 32'd1);
    chk("restart_fd", 32'(FrameDone), 32'd0);

    // Random traffic with a mid-run asynchronous reset
    en_r = 1'b1; mode_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_line", 32'(Line), 32'd0);
        chk("midrst_row", 32'(RowIdx), 32'd0);
        chk("midrst_fd", 32'(FrameDone), 32'd0);
        chk("midrst_disp", 32'(Display), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
      end
      en_r = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) mode_r = ~mode_r;
      step(en_r, mode_r, 3'($urandom_range(7)));
      chk("onehot_at_most_one", 32'($countones(Line) <= 1), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
